lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store sequencer between the core's memory stage and the word-addressed, byte-enabled data RAM.
//  Takes byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests and drives the RAM's word index, byte enables and lane-shifted write data.
//  Splits word-boundary-crossing accesses into two RAM cycles and returns aligned, sign/zero-extended load data.
//  RAM read data is combinational (valid in the same cycle as addr + MemRead). RAM writes occur on the clock edge.
// PARAMETERS
//  MEM_WORDS  256  RAM depth in 32-bit words; power of 2; word index wraps modulo MEM_WORDS
//  SPLIT_EN   1    1: split boundary-crossing accesses; 0: report them as rsp_err with no RAM access
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst_n            in   1   synchronous active-low reset
//  req_valid        in   1   request valid
//  req_ready        out  1   controller can accept a request (high only in IDLE)
//  req_we           in   1   1=store, 0=load
//  req_funct3       in   3   RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr         in   32  byte address
//  req_wdata        in   32  store data, right-aligned
//  rsp_valid        out  1   response valid; held until rsp_ready
//  rsp_ready        in   1   response accepted
//  rsp_rdata        out  32  load result, extended (0 for stores and errors)
//  rsp_err          out  1   illegal funct3, or crossing access with SPLIT_EN=0
//  rsp_split        out  1   access used two RAM cycles
//  mem_MemRead      out  1   RAM read enable
//  mem_MemWrite     out  1   RAM write enable
//  mem_byte_enable  out  4   RAM byte lanes
//  mem_addr         out  32  RAM word index = {2'b0, byte_addr[31:2]} mod MEM_WORDS
//  mem_w_data       out  32  lane-shifted store data
//  mem_r_data       in   32  RAM read data
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge): state IDLE. req_ready=1. rsp_valid/rsp_err/rsp_split=0. rsp_rdata=0.
//   All mem_* outputs are 0. An in-flight transaction is dropped. A first store half already written is not rolled back.
//  States:
//   IDLE: req_ready=1. On req_valid -> latch request. Go to ACC0, or to RESP if the request is an error.
//   ACC0: first RAM access. If crossing -> ACC1, else -> RESP.
//   ACC1: second RAM access, word index +1 mod MEM_WORDS. Then -> RESP.
//   RESP: rsp_valid=1, rsp_* held stable. If rsp_ready -> IDLE.
//  Latency: request accepted at edge T. Aligned: rsp_valid from T+2. Crossing: from T+3. Error: from T+1.
//   Back-to-back requests have at least 1 IDLE cycle between them.
//  Sizes and offsets:
//   s=1/2/4 bytes for B/BU, H/HU, W. o=addr[1:0]. crossing iff o+s>4.
//   Halfword at o=1 is a single access (not split).
//  Legal funct3:
//   loads: 000, 001, 010, 100, 101.
//   stores: 000, 001, 010.
//   Any other funct3 is an error: rsp_err=1, rdata=0, no mem access.
//  Byte enables:
//   ACC0: be = ((1<<s)-1)<<o, truncated to 4 bits.
//   ACC1: be = ((1<<s)-1)>>(4-o).
//  Write data:
//   ACC0: w_data = wdata<<(8*o).
//   ACC1: w_data = wdata>>(8*(4-o)).
//   Store: MemWrite=1 only in ACC states. Load: MemRead=1 only in ACC states.
//  Load data:
//   mem_r_data is captured at the end of each ACC cycle into word0/word1.
//   raw = {word1, word0} >> (8*o); keep the low s bytes.
//   Sign-extend for B/H. Zero-extend for BU/HU.
//  Outside ACC states all mem_* outputs are 0.
//  Requests presented while req_ready=0 are ignored (not latched).
// TESTING
//  SW 0x10 data 0xDEADBEEF -> one cycle: mem_addr=4, be=1111, w_data=0xDEADBEEF.
//   Then LW 0x10 -> rsp_rdata=0xDEADBEEF at T+2, rsp_split=0.
//  SB 0x13 data 0xA5 -> be=1000, w_data=0xA5000000.
//   Then LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
//  SW 0x0E data 0x11223344 -> ACC0: idx 3, be=1100, w_data=0x33440000. ACC1: idx 4, be=0011, w_data=0x00001122.
//   Then LW 0x0E -> 0x11223344 at T+3, rsp_split=1.
//  MEM_WORDS=256, SH 0x3FF data 0xBEEF -> idx 255 be=1000, then idx 0 be=0001 (wrap).
//   LHU 0x3FF -> 0x0000BEEF.
//  Load funct3=011 -> no MemRead, rsp_err=1, rdata=0 at T+1.
//   With SPLIT_EN=0, LW 0x02 -> rsp_err=1, no RAM access.
//  rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0.
//   rst_n=0 during ACC1 -> next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store sequencer between the core memory stage and a word-addressed,
// byte-enabled data RAM. A byte-addressed request (LB/LH/LW/LBU/LHU/SB/SH/SW)
// becomes one RAM cycle, or two when the access crosses a word boundary. Load
// data comes back aligned and sign/zero-extended.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we, req_funct3    store flag and RV32I size/sign code
//   req_addr, req_wdata   byte address, right-aligned store data
//   rsp_valid/rsp_ready   response handshake (valid held until ready)
//   rsp_rdata             extended load data (0 for stores and errors)
//   rsp_err, rsp_split    illegal request / access used two RAM cycles
//   mem_*                 RAM read/write enables, byte lanes, word index,
//                         lane-shifted write data, combinational read data
//
// Every output is a flop. The mem_* flops are loaded with the values for the
// state being entered, so they are valid for the whole RAM cycle.
// ----------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 256,
    parameter bit SPLIT_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_split,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_r_data
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Legal funct3 codes; unsigned loads have no store counterpart.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte lanes over two consecutive words: [3:0] first word, [7:4] second.
    // The access crosses a word boundary exactly when [7:4] is non-zero.
    function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [7:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << off;
    endfunction

    // Store data shifted into lanes across two words, same split as lane_mask.
    function automatic logic [63:0] lane_data(input logic [31:0] d, input logic [1:0] off);
        return {32'h0000_0000, d} << {off, 3'b000};
    endfunction

    // Sign or zero extension of the right-aligned raw load bytes.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] v;
        case (f3)
            3'b000:  v = {{24{raw[7]}}, raw[7:0]};
            3'b001:  v = {{16{raw[15]}}, raw[15:0]};
            3'b100:  v = {24'h00_0000, raw[7:0]};
            3'b101:  v = {16'h0000, raw[15:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_we;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic            r_cross;
    logic [31:0]     r_word0;

    logic            r_req_ready;
    logic            r_rsp_valid;
    logic [31:0]     r_rsp_rdata;
    logic            r_rsp_err;
    logic            r_rsp_split;
    logic            r_mem_rd;
    logic            r_mem_wr;
    logic [3:0]      r_mem_be;
    logic [AW-1:0]   r_mem_idx;
    logic [31:0]     r_mem_wd;

    logic [7:0]      w_req_lanes;
    logic [63:0]     w_req_wd64;
    logic            w_req_cross;
    logic            w_req_err;
    logic [AW-1:0]   w_req_idx;
    logic [7:0]      w_r_lanes;
    logic [63:0]     w_r_wd64;
    logic [AW-1:0]   w_idx_inc;
    logic [31:0]     w_ld_lo;
    logic [31:0]     w_ld_hi;
    logic [31:0]     w_ld_raw;
    logic [31:0]     w_ld_data;
    logic            w_accept;
    logic            w_unused_addr;

    logic            w_nxt_rd;
    logic            w_nxt_wr;
    logic [3:0]      w_nxt_be;
    logic [AW-1:0]   w_nxt_idx;
    logic [31:0]     w_nxt_wd;
    logic            w_nxt_rsp_valid;
    logic [31:0]     w_nxt_rsp_rdata;
    logic            w_nxt_rsp_err;
    logic            w_nxt_rsp_split;

    assign w_req_lanes   = lane_mask(req_funct3, req_addr[1:0]);
    assign w_req_wd64    = lane_data(req_wdata, req_addr[1:0]);
    assign w_req_cross   = |w_req_lanes[7:4];
    assign w_req_err     = ~f3_legal(req_we, req_funct3) | (w_req_cross & (SPLIT_EN == 1'b0));
    assign w_req_idx     = req_addr[AW+1:2];
    assign w_unused_addr = ^req_addr[31:AW+2];

    assign w_r_lanes     = lane_mask(r_f3, r_off);
    assign w_r_wd64      = lane_data(r_wdata, r_off);
    assign w_idx_inc     = r_idx + {{(AW-1){1'b0}}, 1'b1};

    // In ACC1 the first word is already captured and the second arrives now;
    // in ACC0 only the current word matters because the access does not cross.
    assign w_ld_lo       = (r_state == ST_ACC1) ? r_word0 : mem_r_data;
    assign w_ld_hi       = (r_state == ST_ACC1) ? mem_r_data : 32'h0000_0000;
    assign w_ld_raw      = 32'({w_ld_hi, w_ld_lo} >> {r_off, 3'b000});
    assign w_ld_data     = load_extend(r_f3, w_ld_raw);

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_nxt_rd        = 1'b0;
        w_nxt_wr        = 1'b0;
        w_nxt_be        = 4'b0000;
        w_nxt_idx       = {AW{1'b0}};
        w_nxt_wd        = 32'h0000_0000;
        w_nxt_rsp_valid = 1'b0;
        w_nxt_rsp_rdata = 32'h0000_0000;
        w_nxt_rsp_err   = 1'b0;
        w_nxt_rsp_split = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_req_err ? ST_RESP : ST_ACC0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACC0: begin
                if (r_cross) begin
                    w_state_nxt = ST_ACC1;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_ACC1: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // ACC0 is only ever entered from IDLE, so it takes the live request.
        case (w_state_nxt)
            ST_ACC0: begin
                w_nxt_rd  = ~req_we;
                w_nxt_wr  = req_we;
                w_nxt_be  = w_req_lanes[3:0];
                w_nxt_idx = w_req_idx;
                w_nxt_wd  = req_we ? w_req_wd64[31:0] : 32'h0000_0000;
            end
            ST_ACC1: begin
                w_nxt_rd  = ~r_we;
                w_nxt_wr  = r_we;
                w_nxt_be  = w_r_lanes[7:4];
                w_nxt_idx = w_idx_inc;
                w_nxt_wd  = r_we ? w_r_wd64[63:32] : 32'h0000_0000;
            end
            ST_RESP: begin
                w_nxt_rsp_valid = 1'b1;
                if (r_state == ST_RESP) begin
                    w_nxt_rsp_rdata = r_rsp_rdata;
                    w_nxt_rsp_err   = r_rsp_err;
                    w_nxt_rsp_split = r_rsp_split;
                end else if (r_state == ST_IDLE) begin
                    w_nxt_rsp_err   = 1'b1;
                end else begin
                    w_nxt_rsp_split = r_cross;
                    w_nxt_rsp_rdata = r_we ? 32'h0000_0000 : w_ld_data;
                end
            end
            default: begin
                w_nxt_rd = 1'b0;
            end
        endcase
    end

    // State, latched request, captured read word and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_idx       <= {AW{1'b0}};
            r_wdata     <= 32'h0000_0000;
            r_cross     <= 1'b0;
            r_word0     <= 32'h0000_0000;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
            r_rsp_split <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_idx   <= {AW{1'b0}};
            r_mem_wd    <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_off   <= req_addr[1:0];
                r_idx   <= w_req_idx;
                r_wdata <= req_wdata;
                r_cross <= w_req_cross;
            end
            if (r_state == ST_ACC0) begin
                r_word0 <= mem_r_data;
            end
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= w_nxt_rsp_valid;
            r_rsp_rdata <= w_nxt_rsp_rdata;
            r_rsp_err   <= w_nxt_rsp_err;
            r_rsp_split <= w_nxt_rsp_split;
            r_mem_rd    <= w_nxt_rd;
            r_mem_wr    <= w_nxt_wr;
            r_mem_be    <= w_nxt_be;
            r_mem_idx   <= w_nxt_idx;
            r_mem_wd    <= w_nxt_wd;
        end
    end

    assign req_ready       = r_req_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_err         = r_rsp_err;
    assign rsp_split       = r_rsp_split;
    assign mem_MemRead     = r_mem_rd;
    assign mem_MemWrite    = r_mem_wr;
    assign mem_byte_enable = r_mem_be;
    assign mem_addr        = {{(32-AW){1'b0}}, r_mem_idx};
    assign mem_w_data      = r_mem_wd;

endmodule
